// File: rtl/prime_dpe_seq_if.sv
// Command, operand-stream and DPE control bundle for prime_dpe_seq_ctrl.
// master = command/stream source, slave = the sequencer.
interface prime_dpe_seq_if #(
  parameter int VEC_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load_w;
  logic [VEC_W-1:0] cmd_num_vec;
  logic             in_valid;
  logic             in_ready;
  logic [95:0]      in_data;
  logic             dpe_ena;
  logic [95:0]      dpe_data_in;
  logic             dpe_load_bb_one;
  logic             dpe_load_bb_two;
  logic             dpe_load_buf_sel;
  logic [1:0]       dpe_feed_sel;
  logic             dpe_zero_en;
  logic             res_valid;
  logic             res_last;
  logic             busy;
  logic [31:0]      perf_busy_cnt;
  logic [31:0]      perf_stall_cnt;

  modport master (
    output cmd_valid, cmd_load_w, cmd_num_vec, in_valid, in_data,
    input  cmd_ready, in_ready, dpe_ena, dpe_data_in, dpe_load_bb_one, dpe_load_bb_two,
           dpe_load_buf_sel, dpe_feed_sel, dpe_zero_en, res_valid, res_last, busy,
           perf_busy_cnt, perf_stall_cnt
  );

  modport slave (
    input  cmd_valid, cmd_load_w, cmd_num_vec, in_valid, in_data,
    output cmd_ready, in_ready, dpe_ena, dpe_data_in, dpe_load_bb_one, dpe_load_bb_two,
           dpe_load_buf_sel, dpe_feed_sel, dpe_zero_en, res_valid, res_last, busy,
           perf_busy_cnt, perf_stall_cnt
  );
endinterface

// File: rtl/prime_dpe_seq_ctrl.sv
// Sequencer for one INT8 dot-product engine with ping-pong weight buffers.
// Optional busy/stall counters are built when PRIME_DPE_SEQ_PERF_EN is defined.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// LOAD  | three weight beats into the shadow buffer, then swap
// RUN   | streaming activation vectors, one per accept
// DRAIN | waiting for in-flight results to leave the pipe
module prime_dpe_seq_ctrl #(
  parameter logic [1:0] FEED_SEL = 2'b00,
  parameter int         VEC_W    = 16,
  parameter int         LAT      = 4
) (
  input logic            clk,
  input logic            clr,
  prime_dpe_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  localparam bit               CASCADE = (FEED_SEL != 2'b00);
  localparam logic [VEC_W-1:0] ONE     = {{(VEC_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [VEC_W-1:0] remain, remain_nxt;
  logic [1:0]       beat, beat_nxt;
  logic             buf_sel, buf_sel_nxt;
  logic [95:0]      data_q;
  logic [LAT-1:0]   pipe_v, pipe_l;
  logic             rdy, beat_go, run_acc, stall, busy_i;

  always_comb begin
    state_nxt   = state;
    remain_nxt  = remain;
    beat_nxt    = beat;
    buf_sel_nxt = buf_sel;
    rdy         = 1'b0;
    beat_go     = 1'b0;
    run_acc     = 1'b0;
    stall       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          remain_nxt = bus.cmd_num_vec;
          beat_nxt   = 2'd0;
          if (bus.cmd_load_w)
            state_nxt = LOAD;
          else if (bus.cmd_num_vec != '0)
            state_nxt = RUN;
        end
      end
      LOAD: begin
        // Cascade weights arrive on a side path, so every LOAD cycle is a beat.
        rdy     = !CASCADE;
        beat_go = CASCADE ? 1'b1 : bus.in_valid;
        stall   = !CASCADE && !bus.in_valid;
        if (beat_go) begin
          beat_nxt = beat + 2'd1;
          if (beat == 2'd2) begin
            beat_nxt    = 2'd0;
            buf_sel_nxt = ~buf_sel;
            state_nxt   = (remain != '0) ? RUN : IDLE;
          end
        end
      end
      RUN: begin
        rdy     = 1'b1;
        run_acc = bus.in_valid;
        stall   = !bus.in_valid;
        if (run_acc) begin
          remain_nxt = remain - ONE;
          if (remain == ONE)
            state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Holding here until the pipe empties keeps the next swap off in-flight MACs.
        if (pipe_v == '0)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      remain  <= '0;
      beat    <= 2'd0;
      buf_sel <= 1'b0;
      data_q  <= '0;
      pipe_v  <= '0;
      pipe_l  <= '0;
    end else begin
      state   <= state_nxt;
      remain  <= remain_nxt;
      beat    <= beat_nxt;
      buf_sel <= buf_sel_nxt;
      if (bus.in_valid && rdy)
        data_q <= bus.in_data;
      pipe_v <= {pipe_v[LAT-2:0], run_acc};
      pipe_l <= {pipe_l[LAT-2:0], run_acc && (remain == ONE)};
    end
  end

  assign busy_i               = (state != IDLE) || (pipe_v != '0);
  assign bus.cmd_ready        = (state == IDLE);
  assign bus.in_ready         = rdy;
  assign bus.dpe_ena          = (state != IDLE);
  assign bus.dpe_data_in      = data_q;
  assign bus.dpe_load_bb_one  = beat_go && buf_sel;
  assign bus.dpe_load_bb_two  = beat_go && !buf_sel;
  assign bus.dpe_load_buf_sel = buf_sel;
  assign bus.dpe_feed_sel     = FEED_SEL;
  assign bus.res_valid        = pipe_v[LAT-1];
  assign bus.res_last         = pipe_l[LAT-1];
  assign bus.dpe_zero_en      = ~pipe_v[LAT-1];
  assign bus.busy             = busy_i;

`ifdef PRIME_DPE_SEQ_PERF_EN
  logic [31:0] busy_cnt, stall_cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      busy_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (busy_i && (busy_cnt != '1))
        busy_cnt <= busy_cnt + 32'd1;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.perf_busy_cnt  = busy_cnt;
  assign bus.perf_stall_cnt = stall_cnt;
`else
  assign bus.perf_busy_cnt  = 32'd0;
  assign bus.perf_stall_cnt = 32'd0;
`endif
endmodule

// File: doc/prime_dpe_seq_ctrl.md
# prime_dpe_seq_ctrl

Sequencer for one INT8 tensor dot-product engine (DPE) with ping-pong weight buffers; sits between the tile's operand stream and the DPE.
- Accepts commands that optionally load a 3-row weight set into the shadow buffer, swap buffers, and stream N activation vectors.
- Drives all DPE load, select and enable controls, with timing matched to the DPE's internal register stages.
- Flags the DPE result bus valid on exactly the cycles that carry a finished dot product.

## Interface
- `FEED_SEL`, 2'b00: weight source driven to DPE. 2'b00 = local data bus; any other value = cascade input.
- `VEC_W`, 16: width of the vector-count field.
- `LAT`, 4: cycles from stream accept to DPE result valid.
- `clk` in 1: clock.
- `clr` in 1: synchronous active-high reset; the same net also drives DPE `clr`.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_load_w` in 1: load a new weight set before computing.
- `cmd_num_vec` in VEC_W: number of activation vectors; 0 is legal.
- `in_valid` in 1: operand stream beat valid.
- `in_ready` out 1: operand stream beat accepted on `in_valid & in_ready`.
- `in_data` in 96: operand beat; weights use bits [87:0], activations use [79:0].
- `dpe_ena` out 1: high while not IDLE.
- `dpe_data_in` out 96: registered `in_data`.
- `dpe_load_bb_one`, `dpe_load_bb_two` out 1 each: buffer shift enables.
- `dpe_load_buf_sel` out 1: active buffer; 0 = bb_one.
- `dpe_feed_sel` out 2: constant `FEED_SEL`.
- `dpe_zero_en` out 1: equals `~res_valid`.
- `res_valid` out 1: DPE `result_h`/`result_l` carry a valid result this cycle.
- `res_last` out 1: marks the final result of a command.
- `busy` out 1: not IDLE, or any result still in flight.
- `perf_busy_cnt`, `perf_stall_cnt` out 32 each: see Configuration.

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - On `cmd_valid`: latch `cmd_load_w` and `cmd_num_vec`.
  - If `cmd_load_w` = 1, go to LOAD.
  - Else if the count is nonzero, go to RUN.
  - Else stay in IDLE; the command is consumed and produces no results.
- LOAD:
  - Requires exactly 3 weight beats.
  - Local mode: a beat is an accept.
  - Cascade mode: a beat is one cycle; `in_ready` = 0 and no stream beat is consumed.
  - During each beat, assert the shadow buffer's load (`dpe_load_bb_one` if `dpe_load_buf_sel`=1, else `dpe_load_bb_two`). This is combinational from the beat qualifier.
  - `dpe_data_in` <= `in_data` on accept, so the data reaches the DPE one cycle after the load strobe, matching the DPE's registered strobe.
  - Row order: beat 0 ends in row 2 (`result_h` upper field); beat 2 ends in row 0.
  - After beat 2: toggle `dpe_load_buf_sel`.
  - Then go to RUN if count > 0; otherwise go to IDLE (weights loaded, no compute).
- RUN:
  - `in_ready` = 1. Each accept decrements the remaining count and sets `dpe_data_in`.
  - Load strobes are held low.
  - The last accept moves to DRAIN.
- DRAIN: wait until the result pipeline is empty, then go to IDLE. This guarantees that a following buffer swap never overlaps in-flight multiplies.
- Result tracking: a LAT-deep shift register carries `{valid,last}` per RUN accept; its output is `res_valid`/`res_last`.
- Stall: in LOAD(local) or RUN with `in_valid`=0. Bubbles propagate as `res_valid`=0 gaps.
- Mid-operation `clr` resets:
  - FSM to IDLE, counters and result pipe cleared.
  - `dpe_load_buf_sel` to 0, `dpe_data_in` to 0.
  - Partial weight loads are discarded.

## Timing
- Reset values:
  - `cmd_ready` = 1.
  - `dpe_zero_en` = 1.
  - All other outputs 0, except `dpe_feed_sel` = `FEED_SEL`.
- Accept at cycle t gives: `dpe_data_in` at t+1, DPE input register at t+2, dot sum at t+3, accumulated result and `res_valid` at t+4 (LAT=4).
- The buffer swap takes effect the cycle after beat 2; the earliest RUN accept is that cycle.
- Back-to-back command: the new command is accepted the cycle after DRAIN → IDLE.
- Throughput: 1 vector/cycle in RUN.
- Minimum LOAD length: 3 cycles.

## Configuration
- `PRIME_DPE_SEQ_PERF_EN` defined:
  - `perf_busy_cnt` increments each cycle `busy`=1.
  - `perf_stall_cnt` increments each stall cycle.
  - Both saturate at 2^32-1 and are cleared by `clr`.
- Not defined: both ports are tied to 0 and no counter logic is built.

## Test plan
- Load + 4 vectors, local mode:
  - Stimulus: weight rows all +1, then activations with every byte = 2.
  - Required: `dpe_load_bb_two` high 3 cycles; then `dpe_load_buf_sel`=1; then `res_valid` for 4 consecutive cycles starting 4 cycles after the first RUN accept; each row result = 20; `res_last` on the 4th.
- Second command with load:
  - Required: strobes go to `dpe_load_bb_one`; `dpe_load_buf_sel` returns to 0.
  - With weight bytes -3 and activation bytes 5: each row result = -150.
- `cmd_load_w`=0, `cmd_num_vec`=0: `cmd_ready` stays high; no strobes; `res_valid` stays 0.
- Stall: deassert `in_valid` for 2 cycles mid-RUN of 6 vectors → exactly 6 `res_valid` pulses with a 2-cycle gap; with the macro, `perf_stall_cnt`=2.
- Cascade mode (`FEED_SEL`=2'b01): LOAD lasts exactly 3 cycles with `in_ready`=0 and no stream beats consumed.
- `clr` asserted during LOAD beat 2: next cycle all outputs are at reset values, `dpe_load_buf_sel`=0, `busy`=0.
